regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we3/wa3/wd3) between two writeback sources: the ALU and the load/memory unit.
- Each source has a small queue with a valid/ready handshake. Arbitration is ALU-priority with load-aging anti-starvation.
- R15 writes are diverted to a PC-write output, because the register file serves R15 reads from the PC.
- A per-register busy vector goes to hazard/stall logic.

---
 rtl/regfile_wb_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_fifo.sv | 72 +++++++
 rtl/regfile_wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// Entry layout, writeback source tags and the PC register index.
package regfile_wb_pkg;

    localparam int WB_DW = 32;
    localparam logic [3:0] PC_IDX = 4'd15;

    typedef struct packed {
        logic [3:0]       wa;
        logic [WB_DW-1:0] wd;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small circular queue of writeback entries with a per-slot
// valid/address view used to build the busy vector.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  wb_entry_t             entry_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output wb_entry_t             head_o,
    output logic [DEPTH-1:0]      vld_o,
    output logic [DEPTH-1:0][3:0] wa_o
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    logic [AW-1:0] off;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= entry_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below count
    always_comb begin
        vld_o = '0;
        wa_o  = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = AW'(i) - rd_q;
            vld_o[i] = ({1'b0, off} < cnt_q);
            wa_o[i]  = mem_q[i].wa;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port.
// Optional decode forwarding taps: define REGFILE_WB_FWD_EN.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 3,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [3:0]    alu_wa,
    input  logic [DW-1:0] alu_wd,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [3:0]    ld_wa,
    input  logic [DW-1:0] ld_wd,
    output logic          we3,
    output logic [3:0]    wa3,
    output logic [DW-1:0] wd3,
    output logic          pc_we,
    output logic [DW-1:0] pc_wd,
    output logic [15:0]   busy
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [3:0]    fra1,
    input  logic [3:0]    fra2,
    output logic          fwd1_hit,
    output logic          fwd2_hit,
    output logic [DW-1:0] fwd1_data,
    output logic [DW-1:0] fwd2_data
`endif
);

    localparam int AGW = $clog2(MAX_WAIT + 1);

    wb_entry_t alu_in, ld_in, alu_head, ld_head, sel_e;
    logic alu_full, alu_empty, ld_full, ld_empty;
    logic alu_pop, ld_pop, sel_vld, pick_ld;
    wb_src_e sel_src;
    logic [DEPTH-1:0]      alu_vld, ld_vld;
    logic [DEPTH-1:0][3:0] alu_wav, ld_wav;

    logic [AGW-1:0] ld_age_q, ld_age_d;
    logic           we3_q, we3_d, pc_we_q, pc_we_d;
    logic [3:0]     wa3_q, wa3_d;
    logic [DW-1:0]  wd3_q, wd3_d, pc_wd_q, pc_wd_d;

    assign alu_in    = '{wa: alu_wa, wd: alu_wd};
    assign ld_in     = '{wa: ld_wa, wd: ld_wd};
    assign alu_ready = !alu_full;
    assign ld_ready  = !ld_full;

    wb_fifo #(.DEPTH(DEPTH)) u_alu_q (
        .clk     (clk),
        .reset   (reset),
        .push_i  (alu_valid && alu_ready),
        .entry_i (alu_in),
        .pop_i   (alu_pop),
        .full_o  (alu_full),
        .empty_o (alu_empty),
        .head_o  (alu_head),
        .vld_o   (alu_vld),
        .wa_o    (alu_wav)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_ld_q (
        .clk     (clk),
        .reset   (reset),
        .push_i  (ld_valid && ld_ready),
        .entry_i (ld_in),
        .pop_i   (ld_pop),
        .full_o  (ld_full),
        .empty_o (ld_empty),
        .head_o  (ld_head),
        .vld_o   (ld_vld),
        .wa_o    (ld_wav)
    );

    // ALU has priority until the load head has lost MAX_WAIT times
    always_comb begin
        pick_ld = !ld_empty
               && (alu_empty || ld_age_q == AGW'(MAX_WAIT));
        sel_vld = !alu_empty || !ld_empty;
        sel_src = pick_ld ? SRC_LD : SRC_ALU;
        sel_e   = (sel_src == SRC_LD) ? ld_head : alu_head;
        alu_pop = sel_vld && (sel_src == SRC_ALU);
        ld_pop  = sel_vld && (sel_src == SRC_LD);
    end

    always_comb begin
        ld_age_d = ld_age_q;
        if (ld_empty || ld_pop) begin
            ld_age_d = '0;
        end else if (ld_age_q != AGW'(MAX_WAIT)) begin
            ld_age_d = ld_age_q + 1'b1;
        end
    end

    always_comb begin
        we3_d   = 1'b0;
        pc_we_d = 1'b0;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        pc_wd_d = pc_wd_q;
        if (sel_vld) begin
            if (sel_e.wa == PC_IDX) begin
                pc_we_d = 1'b1;
                pc_wd_d = sel_e.wd;
            end else begin
                we3_d = 1'b1;
                wa3_d = sel_e.wa;
                wd3_d = sel_e.wd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_age_q <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            pc_we_q  <= 1'b0;
            pc_wd_q  <= '0;
        end else begin
            ld_age_q <= ld_age_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            pc_we_q  <= pc_we_d;
            pc_wd_q  <= pc_wd_d;
        end
    end

    assign we3   = we3_q;
    assign wa3   = wa3_q;
    assign wd3   = wd3_q;
    assign pc_we = pc_we_q;
    assign pc_wd = pc_wd_q;

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_vld[i]) busy[alu_wav[i]] = 1'b1;
            if (ld_vld[i])  busy[ld_wav[i]]  = 1'b1;
        end
        if (we3_q)   busy[wa3_q]  = 1'b1;
        if (pc_we_q) busy[PC_IDX] = 1'b1;
    end

`ifdef REGFILE_WB_FWD_EN
    assign fwd1_hit  = we3_q && (wa3_q == fra1) && (fra1 != PC_IDX);
    assign fwd2_hit  = we3_q && (wa3_q == fra2) && (fra2 != PC_IDX);
    assign fwd1_data = fwd1_hit ? wd3_q : '0;
    assign fwd2_data = fwd2_hit ? wd3_q : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed writes, expected
// issue order queued up front, a negedge monitor compares each write.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic        pc;
        logic [3:0]  wa;
        logic [31:0] wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic        alu_ready, ld_ready;
    logic [3:0]  alu_wa = '0, ld_wa = '0;
    logic [31:0] alu_wd = '0, ld_wd = '0;
    logic        we3, pc_we;
    logic [3:0]  wa3;
    logic [31:0] wd3, pc_wd;
    logic [15:0] busy;
`ifdef REGFILE_WB_FWD_EN
    logic [3:0]  fra1 = '0, fra2 = '0;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    exp_t sb[$];
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    int   wr_seen = 0;
    int   snap;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(2), .MAX_WAIT(3), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_wa     (ld_wa),
        .ld_wd     (ld_wd),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .pc_we     (pc_we),
        .pc_wd     (pc_wd),
        .busy      (busy)
`ifdef REGFILE_WB_FWD_EN
        ,
        .fra1      (fra1),
        .fra2      (fra2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
`endif
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expw(input logic pc, input logic [3:0] wa,
                        input logic [31:0] wd);
        exp_t e;
        e.pc = pc;
        e.wa = wa;
        e.wd = wd;
        sb.push_back(e);
    endtask

    task automatic alu_send(input logic [3:0] wa, input logic [31:0] wd);
        int  n = 0;
        logic ok;
        alu_valid = 1'b1;
        alu_wa = wa;
        alu_wd = wd;
        do begin
            ok = alu_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok) check("alu_accept_timeout", 32'd0, 32'd1);
        alu_valid = 1'b0;
    endtask

    task automatic ld_send(input logic [3:0] wa, input logic [31:0] wd);
        int  n = 0;
        logic ok;
        ld_valid = 1'b1;
        ld_wa = wa;
        ld_wd = wd;
        do begin
            ok = ld_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok) check("ld_accept_timeout", 32'd0, 32'd1);
        ld_valid = 1'b0;
    endtask

    // Monitor: every issued write must match the next expected one
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (we3 || pc_we)) begin
            wr_seen++;
            if (sb.size() == 0) begin
                check("sb_unexpected_write", {27'd0, pc_we, wa3}, 32'hdead);
            end else begin
                e = sb.pop_front();
                check("sb_is_pc", {31'd0, pc_we}, {31'd0, e.pc});
                check("sb_we3_excl", {31'd0, we3}, {31'd0, !e.pc});
                if (e.pc) begin
                    check("sb_pc_wd", pc_wd, e.wd);
                end else begin
                    check("sb_wa3", {28'd0, wa3}, {28'd0, e.wa});
                    check("sb_wd3", wd3, e.wd);
                end
            end
        end
    end

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_we3", {31'd0, we3}, 32'd0);
        check("rst_pc_we", {31'd0, pc_we}, 32'd0);
        check("rst_wa3", {28'd0, wa3}, 32'd0);
        check("rst_wd3", wd3, 32'd0);
        check("rst_pc_wd", pc_wd, 32'd0);
        check("rst_busy", {16'd0, busy}, 32'd0);
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        tick();
        tick();
        reset = 1'b0;

        // Single ALU write and its busy window
        expw(0, 4'd1, 32'h11);
        alu_send(4'd1, 32'h11);
        @(negedge clk);
        check("t1_busy_queued", {16'd0, busy}, 32'h0002);
        check("t1_we3_not_yet", {31'd0, we3}, 32'd0);
        tick();
        @(negedge clk);
        check("t1_we3_high", {31'd0, we3}, 32'd1);
        check("t1_busy_issue", {16'd0, busy}, 32'h0002);
        tick();
        @(negedge clk);
        check("t1_we3_low", {31'd0, we3}, 32'd0);
        check("t1_busy_clear", {16'd0, busy}, 32'd0);
        repeat (2) tick();

        // Same-edge conflict: ALU first, load next
        expw(0, 4'd2, 32'hA);
        expw(0, 4'd3, 32'hB);
        fork
            alu_send(4'd2, 32'hA);
            ld_send(4'd3, 32'hB);
        join
        @(negedge clk);
        check("t2_busy_queued", {16'd0, busy}, 32'h000C);
        tick();
        @(negedge clk);
        check("t2_busy_first", {16'd0, busy}, 32'h000C);
        tick();
        @(negedge clk);
        check("t2_busy_second", {16'd0, busy}, 32'h0008);
        repeat (3) tick();

        // Anti-starvation: load forced after three ALU wins
        for (int i = 0; i < 3; i++) expw(0, 4'd8, 32'h80 + i);
        expw(0, 4'd4, 32'h44);
        for (int i = 3; i < 6; i++) expw(0, 4'd8, 32'h80 + i);
        fork
            begin
                for (int i = 0; i < 6; i++) alu_send(4'd8, 32'h80 + i);
            end
            ld_send(4'd4, 32'h44);
        join
        repeat (8) tick();

        // Load queue full while ALU streams
        for (int i = 0; i < 3; i++) expw(0, 4'd9, 32'h90 + i);
        expw(0, 4'd5, 32'h55);
        for (int i = 3; i < 6; i++) expw(0, 4'd9, 32'h90 + i);
        expw(0, 4'd6, 32'h66);
        expw(0, 4'd7, 32'h77);
        fork
            begin
                for (int i = 0; i < 6; i++) alu_send(4'd9, 32'h90 + i);
            end
            begin
                ld_send(4'd5, 32'h55);
                ld_send(4'd6, 32'h66);
                @(negedge clk);
                check("t4_ld_full", {31'd0, ld_ready}, 32'd0);
                ld_send(4'd7, 32'h77);
            end
        join
        repeat (10) tick();

        // R15 goes to the PC port
        expw(1, 4'd15, 32'h100);
        ld_send(4'd15, 32'h100);
        @(negedge clk);
        check("t5_busy15_queued", {16'd0, busy}, 32'h8000);
        tick();
        @(negedge clk);
        check("t5_pc_we", {31'd0, pc_we}, 32'd1);
        check("t5_we3_low", {31'd0, we3}, 32'd0);
        check("t5_wa3_hold", {28'd0, wa3}, 32'd7);
        check("t5_wd3_hold", wd3, 32'h77);
        check("t5_busy15_pulse", {16'd0, busy}, 32'h8000);
        tick();
        @(negedge clk);
        check("t5_pc_we_end", {31'd0, pc_we}, 32'd0);
        check("t5_busy_clear", {16'd0, busy}, 32'd0);
        repeat (2) tick();

        // Async reset with three entries queued
        alu_valid = 1'b1; alu_wa = 4'd10; alu_wd = 32'hA0;
        ld_valid = 1'b1;  ld_wa = 4'd11;  ld_wd = 32'hB0;
        tick();
        alu_wa = 4'd12; alu_wd = 32'hC0;
        ld_wa = 4'd13;  ld_wd = 32'hD0;
        tick();
        alu_valid = 1'b0;
        ld_valid = 1'b0;
        check("t6_busy_pre", {16'd0, busy}, 32'h3C00);
        #2 reset = 1'b1;
        #1;
        check("t6_we3_async", {31'd0, we3}, 32'd0);
        check("t6_busy_async", {16'd0, busy}, 32'd0);
        check("t6_ld_ready_async", {31'd0, ld_ready}, 32'd1);
        snap = wr_seen;
        repeat (2) tick();
        reset = 1'b0;
        repeat (8) tick();
        check("t6_no_stale_write", wr_seen, snap);
        check("t6_busy_idle", {16'd0, busy}, 32'd0);
        check("t6_alu_ready", {31'd0, alu_ready}, 32'd1);

        check("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
